orb_wr_arbiter: RTL and testbench
=================================

# orb_wr_arbiter

Shares the single write port of the orbit-frame RAM between up to NREQ word packers (temperature, status and similar channels). Each packer raises a request with a pre-formatted 12-bit word and RAM address. The arbiter grants one requester at a time and drives a fixed-length write-enable pulse into the RAM. It returns a one-cycle acknowledge to the requester when the write finishes. It sits between the packers and the RAM write port, on the same clock as the frame reader.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 12, RAM word width
- AW, 11, RAM address width
- WE_LEN, 4, cycles ram_we is held high per write (1..31)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester write request, level; held until ack
- req_data  in  NREQ*DW  flattened words; requester i occupies bits [i*DW +: DW]
- req_addr  in  NREQ*AW  flattened addresses; requester i occupies bits [i*AW +: AW]
- hold  in  1  inhibit new grants (frame reader busy); does not abort a write in progress
- ack  out  NREQ  one-hot, one-cycle pulse when requester's write is complete
- grant  out  NREQ  one-hot, current owner of the port; 0 in IDLE
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM write address
- ram_data  out  DW  RAM write data
- busy  out  1  high in any state other than IDLE

## Operation
- Reset values: ack=0, grant=0, ram_we=0, ram_addr=0, ram_data=0, busy=0, state=IDLE, rr pointer=0, we counter=0.
- FSM states:
  - IDLE: if hold=0 and any req bit is set, select a winner and go to LATCH. Otherwise stay.
  - LATCH: register grant (one-hot winner), and register ram_addr and ram_data from the winner's slice. Go to WRITE.
  - WRITE: ram_we=1. The we counter counts 0..WE_LEN-1. When the counter reaches WE_LEN-1, clear the counter and go to DONE.
  - DONE: ram_we=0, ack[winner]=1 for this cycle only, and ram_addr, ram_data and grant are cleared to 0. Go to IDLE.
- Round-robin selection: search from the rr pointer upward, modulo NREQ. The first set req bit wins. In LATCH, the rr pointer is set to winner+1, wrapping NREQ-1 to 0.
- The winner is fixed at the IDLE→LATCH edge. Later changes of req, req_data or req_addr do not affect the transaction. Address and data are captured once, in LATCH.
- If the winner drops req mid-transaction, the write still completes and ack still pulses.
- A requester must drop req in the cycle after it sees ack. A req still high in IDLE is treated as a new request.
- If hold rises during LATCH or WRITE, the current write completes. Hold is evaluated only in IDLE.
- Asynchronous reset in any state forces all outputs to their reset values immediately. A partial write is abandoned and no ack is issued.

## Timing
- req rises before edge k (arbiter in IDLE, hold=0):
  - edge k: enter LATCH.
  - edge k+1: grant, ram_addr and ram_data valid; enter WRITE.
  - edges k+2 .. k+1+WE_LEN: ram_we high for exactly WE_LEN cycles, starting at edge k+2.
  - edge k+2+WE_LEN: ram_we low, ack pulses for one cycle.
  - edge k+3+WE_LEN: back in IDLE.
- Minimum spacing between the ram_we rising edges of back-to-back grants is WE_LEN+3 cycles.
- ram_addr and ram_data are stable throughout ram_we high, and for one cycle before it.
- busy equals (state != IDLE), registered.

## Configuration
- ORB_ARB_FIXED_PRIO_EN defined: fixed priority is used. The lowest-index set req always wins and the rr pointer logic is removed.
- ORB_ARB_FIXED_PRIO_EN undefined (default): round-robin selection as described above.

## Test plan
- Single request: req=4'b0100, req_addr[2]=831, req_data[2]=12'h5A4. Required response:
  - grant=4'b0100 and ram_addr=831 one cycle after LATCH entry.
  - ram_we high 4 cycles with ram_data=12'h5A4.
  - ack=4'b0100 for one cycle, then all outputs return to 0.
- Simultaneous requests: req=4'b1111 held, each requester dropping req after its ack. Required grant order from reset is 0,1,2,3. With ORB_ARB_FIXED_PRIO_EN, the order is 0,1,2,3 only because requesters drop req; a re-raised req0 beats req3.
- Starvation check: req0 and req3 held permanently. Grants must alternate 0,3,0,3 (round-robin build).
- hold: assert hold=1 with req=4'b0010. No grant while hold=1. Required response:
  - Grant occurs 1 edge after hold falls.
  - Hold raised during WRITE still yields a full 4-cycle ram_we and an ack.
- Mid-transaction changes: the winner changes req_data and drops req during WRITE. ram_data must keep the value captured in LATCH, and ack must still pulse.
- Reset mid-write: assert rst during the 2nd ram_we cycle. Required response:
  - ram_we, grant and ack drop to 0 immediately, with no ack.
  - After release with req still high, a fresh complete transaction runs starting from requester 0.

Source files
------------

// File: rtl/orb_wr_arbiter.sv
// Write-port arbiter for the orbit-frame RAM: grants one packer at a time and drives a fixed-length ram_we pulse.
// Define ORB_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module orb_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DW     = 12,
  parameter int AW     = 11,
  parameter int WE_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic                 hold,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      grant,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_data,
  output logic                 busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(WE_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WE_LEN - 1);

  typedef enum logic [1:0] {IDLE, LATCH, WRITE, DONE} state_t;

  state_t         state;
  logic [IW-1:0]  win_idx;
  logic [CW-1:0]  we_cnt;
  logic [IW-1:0]  pick_idx;
  logic           pick_vld;
  logic [NREQ-1:0] win_oh;
  logic [DW-1:0]  sel_data;
  logic [AW-1:0]  sel_addr;

`ifdef ORB_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_idx = IW'(i);
        pick_vld = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_next;
  logic [IW-1:0] lo_idx;
  logic [IW-1:0] hi_idx;
  logic          hi_vld;

  // Lowest set bit at or above rr_ptr wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_vld   = 1'b0;
    pick_vld = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= rr_ptr) begin
          hi_idx = IW'(i);
          hi_vld = 1'b1;
        end
      end
    end
    pick_idx = hi_vld ? hi_idx : lo_idx;
  end

  assign rr_next = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif

  assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;

  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_data = req_data[i*DW +: DW];
        sel_addr = req_addr[i*AW +: AW];
      end
    end
  end

  // Outputs are registered from the current state, so each lags its state by one cycle;
  // this gives the address/data one cycle of setup before ram_we rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      win_idx  <= '0;
      we_cnt   <= '0;
      grant    <= '0;
      ack      <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      busy     <= 1'b0;
`ifndef ORB_ARB_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          ack <= '0;
          if (!hold && pick_vld) begin
            win_idx <= pick_idx;
            state   <= LATCH;
          end
        end
        LATCH: begin
          grant    <= win_oh;
          ram_addr <= sel_addr;
          ram_data <= sel_data;
          we_cnt   <= '0;
`ifndef ORB_ARB_FIXED_PRIO_EN
          rr_ptr   <= rr_next;
`endif
          state    <= WRITE;
        end
        WRITE: begin
          ram_we <= 1'b1;
          if (we_cnt == CNT_LAST) begin
            we_cnt <= '0;
            state  <= DONE;
          end else begin
            we_cnt <= we_cnt + 1'b1;
          end
        end
        DONE: begin
          ram_we   <= 1'b0;
          ack      <= win_oh;
          grant    <= '0;
          ram_addr <= '0;
          ram_data <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_orb_wr_arbiter.sv
// Directed bench for orb_wr_arbiter: a cycle table for one full write plus hand sequences
// for arbitration order, hold, mid-transaction changes and reset during a write.
module tb_orb_wr_arbiter;
  localparam int NREQ   = 4;
  localparam int DW     = 12;
  localparam int AW     = 11;
  localparam int WE_LEN = 4;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ*AW-1:0]  req_addr;
  logic                hold;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     grant;
  logic                ram_we;
  logic [AW-1:0]       ram_addr;
  logic [DW-1:0]       ram_data;
  logic                busy;

  int passed = 0;
  int total  = 0;

  orb_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .WE_LEN(WE_LEN)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_addr(req_addr),
    .hold(hold), .ack(ack), .grant(grant), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ram_we pulse length and rise spacing monitor
  int cyc = 0;
  int we_run = 0;
  int we_len_last = 0;
  int rise_last = 0;
  int rise_prev = 0;
  logic we_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ram_we) we_run <= we_run + 1;
    else if (we_run != 0) begin
      we_len_last <= we_run;
      we_run <= 0;
    end
    if (ram_we && !we_prev) begin
      rise_prev <= rise_last;
      rise_last <= cyc;
    end
    we_prev <= ram_we;
  end

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [NREQ-1:0] ack;
    logic            busy;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_we(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (ram_we) return;
    end
    total++;
    $display("FAIL wait_we: ram_we stayed 0 for %0d cycles, required a rise", budget);
  endtask

  task automatic wait_ack(input int budget, output logic [NREQ-1:0] a, output logic [NREQ-1:0] g);
    a = '0;
    g = '0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (grant != 0) g = grant;
      if (ack != 0) begin
        a = ack;
        return;
      end
    end
    total++;
    $display("FAIL wait_ack: ack stayed 0 for %0d cycles, required a pulse", budget);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] a, g, exp;
    rst = 1'b1;
    req = '0;
    hold = 1'b0;
    for (int i = 0; i < NREQ; i++) set_slot(i, AW'(100 + i), DW'(12'h100 + i));
    set_slot(2, 11'd831, 12'h5A4);

    // ---- reset values ----
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- single request, cycle table (row i = state after edge k+i) ----
    tbl[0] = '{4'b0100, 4'b0000, 1'b0, 11'd0,   12'h000, 4'b0000, 1'b0};
    tbl[1] = '{4'b0100, 4'b0100, 1'b0, 11'd831, 12'h5A4, 4'b0000, 1'b1};
    tbl[2] = '{4'b0100, 4'b0100, 1'b1, 11'd831, 12'h5A4, 4'b0000, 1'b1};
    tbl[3] = '{4'b0100, 4'b0100, 1'b1, 11'd831, 12'h5A4, 4'b0000, 1'b1};
    tbl[4] = '{4'b0100, 4'b0100, 1'b1, 11'd831, 12'h5A4, 4'b0000, 1'b1};
    tbl[5] = '{4'b0100, 4'b0100, 1'b1, 11'd831, 12'h5A4, 4'b0000, 1'b1};
    tbl[6] = '{4'b0100, 4'b0000, 1'b0, 11'd0,   12'h000, 4'b0100, 1'b1};
    tbl[7] = '{4'b0000, 4'b0000, 1'b0, 11'd0,   12'h000, 4'b0000, 1'b0};
    tbl[8] = '{4'b0000, 4'b0000, 1'b0, 11'd0,   12'h000, 4'b0000, 1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req = tbl[i].req;
      @(posedge clk); #1;
      check($sformatf("tbl[%0d].grant", i), grant, tbl[i].grant);
      check($sformatf("tbl[%0d].we", i), ram_we, tbl[i].we);
      check($sformatf("tbl[%0d].addr", i), ram_addr, tbl[i].addr);
      check($sformatf("tbl[%0d].data", i), ram_data, tbl[i].data);
      check($sformatf("tbl[%0d].ack", i), ack, tbl[i].ack);
      check($sformatf("tbl[%0d].busy", i), busy, tbl[i].busy);
    end

    // ---- all four request, each drops after its ack ----
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      wait_ack(40, a, g);
      exp = 4'b0001 << n;
      check($sformatf("all_req_ack[%0d]", n), a, exp);
      check($sformatf("all_req_grant[%0d]", n), g, exp);
      @(negedge clk);
      req = req & ~a;
    end
    check("all_req_we_len", we_len_last, WE_LEN);

    // ---- req0 and req3 held permanently ----
    do_reset();
    req = 4'b1001;
    for (int n = 0; n < 4; n++) begin
      wait_ack(40, a, g);
`ifdef ORB_ARB_FIXED_PRIO_EN
      exp = 4'b0001;
`else
      exp = (n % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
      check($sformatf("starve_ack[%0d]", n), a, exp);
    end
    @(negedge clk);
    req = '0;
    #1;
    check("b2b_we_spacing", rise_last - rise_prev, WE_LEN + 3);
    repeat (12) @(negedge clk);
    check("starve_idle", busy, 0);

    // ---- hold ----
    do_reset();
    hold = 1'b1;
    req  = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_grant[%0d]", i), grant, 0);
      check($sformatf("hold_busy[%0d]", i), busy, 0);
    end
    @(negedge clk);
    hold = 1'b0;
    @(posedge clk); #1;
    check("hold_latch_grant", grant, 0);
    @(posedge clk); #1;
    check("hold_release_grant", grant, 4'b0010);
    wait_we(10);
    @(negedge clk);
    hold = 1'b1;
    wait_ack(20, a, g);
    check("hold_mid_write_ack", a, 4'b0010);
    @(negedge clk);
    req = '0;
    #1;
    check("hold_mid_write_we_len", we_len_last, WE_LEN);
    @(negedge clk);
    req = 4'b0001;
    repeat (4) @(posedge clk);
    #1;
    check("hold_blocks_new", busy, 0);
    @(negedge clk);
    req  = '0;
    hold = 1'b0;

    // ---- winner changes data and drops req during WRITE ----
    do_reset();
    set_slot(3, 11'h123, 12'hABC);
    req = 4'b1000;
    wait_we(10);
    @(negedge clk);
    set_slot(3, 11'h7FF, 12'h111);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("mid_data[%0d]", i), ram_data, 12'hABC);
      check($sformatf("mid_addr[%0d]", i), ram_addr, 11'h123);
    end
    wait_ack(10, a, g);
    check("mid_ack", a, 4'b1000);
    repeat (4) @(posedge clk);
    #1;
    check("mid_no_regrant", busy, 0);

    // ---- reset during the 2nd ram_we cycle ----
    do_reset();
    req = 4'b0010;
    wait_we(10);
    @(posedge clk); #1;
    check("rstw_we_before", ram_we, 1);
    #2;
    rst = 1'b1;
    req = 4'b0111;
    #1;
    check("rstw_we", ram_we, 0);
    check("rstw_grant", grant, 0);
    check("rstw_ack", ack, 0);
    check("rstw_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("rstw_ack_held", ack, 0);
    rst = 1'b0;
    wait_ack(20, a, g);
    check("rstw_fresh_ack", a, 4'b0001);
    check("rstw_fresh_grant", g, 4'b0001);
    @(negedge clk);
    req = '0;
    #1;
    check("rstw_fresh_we_len", we_len_last, WE_LEN);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
